serial_subtractor: RTL and testbench

//   Bit-serial N-bit subtractor: diff = a - b, computed LSB-first at one bit per clock.

---
 rtl/serial_sub_pkg.sv | 16 +
 rtl/serial_subtractor_if.sv | 37 +++
 rtl/serial_subtractor_fs.sv | 13 +
 rtl/serial_subtractor.sv | 146 ++++++++++++++
 tb/tb_serial_subtractor.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// Shared FSM encodings and helpers for the bit-serial arithmetic blocks.
// The serial subtractor uses this package, and the serial divider is meant to reuse it.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sub_state_e;

  // Signed overflow of a - b: operand signs differ and the result sign left the minuend's.
  function automatic logic sub_ovf(input logic a_sign, input logic b_sign, input logic d_sign);
    return (a_sign != b_sign) && (d_sign != a_sign);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, ovf
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow
  );
`endif

endinterface

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor cell: x - y - bin -> difference bit d, borrow out bout.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, computed LSB-first at one bit per clock over WIDTH cycles.
// Optional signed-overflow output is enabled by the macro SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  serial_subtractor_if.slave  bus
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sub_state_e       state_r;
  sub_state_e       state_s;
  logic             accept_s;
  logic             last_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] diff_r;
  logic [WIDTH:0]   diff_cat_s;
  logic             bflop_r;
  logic [CNT_W-1:0] cnt_r;
  logic             d_s;
  logic             bo_s;

  full_subtractor u_fs (
    .x    (sa_r[0]),
    .y    (sb_r[0]),
    .bin  (bflop_r),
    .d    (d_s),
    .bout (bo_s)
  );

  // Next-state decode; the unused encoding 2'd3 falls back to IDLE.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_s  = ST_RUN;
          accept_s = 1'b1;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // New difference bit enters at the MSB; the oldest bit moves toward the LSB.
  always_comb begin
    diff_cat_s = {d_s, diff_r} >> 1;
    last_s     = (state_r == ST_RUN) && (cnt_r == CNT_LAST);
  end

  // State register, with handshake flags registered alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == ST_IDLE);
      out_valid_r <= (state_s == ST_DONE);
    end
  end

  // Operand shifters, result shift register, borrow flop and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_r    <= '0;
      sb_r    <= '0;
      diff_r  <= '0;
      bflop_r <= 1'b0;
      cnt_r   <= '0;
    end else if (accept_s) begin
      sa_r    <= bus.a;
      sb_r    <= bus.b;
      diff_r  <= '0;
      bflop_r <= 1'b0;
      cnt_r   <= '0;
    end else if (state_r == ST_RUN) begin
      sa_r    <= sa_r >> 1;
      sb_r    <= sb_r >> 1;
      diff_r  <= diff_cat_s[WIDTH-1:0];
      bflop_r <= bo_s;
      cnt_r   <= cnt_r + CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.diff      = diff_r;
  assign bus.borrow    = bflop_r;

`ifdef SERIAL_SUB_OVF_EN
  logic a_sign_r;
  logic b_sign_r;
  logic ovf_r;

  // Sign bits are captured at accept because the operand shifters lose them during RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sign_r <= 1'b0;
      b_sign_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        a_sign_r <= bus.a[WIDTH-1];
        b_sign_r <= bus.b[WIDTH-1];
      end
      if (last_s) begin
        ovf_r <= sub_ovf(a_sign_r, b_sign_r, d_s);
      end else if ((state_r == ST_DONE) && bus.out_ready) begin
        ovf_r <= 1'b0;
      end
    end
  end

  assign bus.ovf = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1 instances).
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic rst1;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus8 ();
  serial_subtractor_if #(.WIDTH(1)) bus1 ();

  serial_subtractor #(.WIDTH(W)) dut8 (.clk(clk), .rst(rst),  .bus(bus8.slave));
  serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint ref_diff(input int w, input longint a, input longint b);
    return (a - b + (longint'(1) << w)) % (longint'(1) << w);
  endfunction

  function automatic longint ref_borrow(input longint a, input longint b);
    return (a < b) ? 1 : 0;
  endfunction

  function automatic longint ref_ovf(input int w, input longint a, input longint b);
    longint half, as, bs, r;
    half = longint'(1) << (w - 1);
    as   = (a >= half) ? a - 2 * half : a;
    bs   = (b >= half) ? b - 2 * half : b;
    r    = as - bs;
    return (r > half - 1 || r < -half) ? 1 : 0;
  endfunction

  // One 8-bit operation starting at a negedge in IDLE; returns at the negedge after IDLE is re-entered.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input int hold, input bit poke);
    int lat;
    check("in_ready_idle", bus8.in_ready, 1);
    bus8.a = av; bus8.b = bv; bus8.in_valid = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom);
    check("in_ready_run", bus8.in_ready, 0);
    lat = 0;
    while (bus8.out_valid !== 1'b1 && lat < 4 * W) begin
      bus8.in_valid = poke;
      bus8.a = 8'($urandom); bus8.b = 8'($urandom);
      @(negedge clk);
      lat++;
    end
    bus8.in_valid = 1'b0;
    check("latency", lat, W);
    check("diff", bus8.diff, ref_diff(W, av, bv));
    check("borrow", bus8.borrow, ref_borrow(av, bv));
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", bus8.ovf, ref_ovf(W, av, bv));
`endif
    check("in_ready_done", bus8.in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      bus8.in_valid = poke;
      @(negedge clk);
      check("hold_valid", bus8.out_valid, 1);
      check("hold_diff", bus8.diff, ref_diff(W, av, bv));
      check("hold_borrow", bus8.borrow, ref_borrow(av, bv));
      check("hold_in_ready", bus8.in_ready, 0);
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
    check("release_valid", bus8.out_valid, 0);
    check("release_in_ready", bus8.in_ready, 1);
`ifdef SERIAL_SUB_OVF_EN
    check("release_ovf", bus8.ovf, 0);
`endif
  endtask

  initial begin
    longint qa[$];
    longint qb[$];
    longint ea, eb;
    int     last_acc;
    int     nres;
    int     lat;

    rst = 1'b1; rst1 = 1'b1;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.a = '0; bus8.b = '0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.a = '0; bus1.b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0; rst1 = 1'b0;

    check("rst_in_ready", bus8.in_ready, 1);
    check("rst_out_valid", bus8.out_valid, 0);
    check("rst_diff", bus8.diff, 0);
    check("rst_borrow", bus8.borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", bus8.ovf, 0);
`endif

    op8(8'h5A, 8'h21, 0, 1'b0);
    op8(8'h10, 8'h20, 0, 1'b0);
    op8(8'h33, 8'h33, 0, 1'b0);
    op8(8'h80, 8'h01, 0, 1'b0);
    op8(8'h7F, 8'hFF, 0, 1'b0);
    op8(8'hC4, 8'h3B, 5, 1'b1);

    // Reset while in RUN.
    bus8.a = 8'hAA; bus8.b = 8'h11; bus8.in_valid = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", bus8.in_ready, 1);
    check("abort_out_valid", bus8.out_valid, 0);
    check("abort_diff", bus8.diff, 0);
    check("abort_borrow", bus8.borrow, 0);
    op8(8'h01, 8'h02, 0, 1'b0);

    // Reset while in DONE.
    bus8.a = 8'h0F; bus8.b = 8'h70; bus8.in_valid = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    repeat (W) @(negedge clk);
    check("done_reached", bus8.out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort2_out_valid", bus8.out_valid, 0);
    check("abort2_diff", bus8.diff, 0);
    check("abort2_borrow", bus8.borrow, 0);

    for (int i = 0; i < 12; i++) begin
      op8(8'($urandom), 8'($urandom), int'($urandom_range(2, 0)), 1'($urandom));
    end

    // WIDTH=1 back-to-back with both handshakes held high.
    bus1.in_valid  = 1'b1;
    bus1.out_ready = 1'b1;
    last_acc = -1;
    nres = 0;
    for (int c = 0; c < 16; c++) begin
      if (c == 0) begin
        bus1.a = 1'b0; bus1.b = 1'b1;
      end else begin
        bus1.a = 1'($urandom); bus1.b = 1'($urandom);
      end
      if (bus1.out_valid === 1'b1) begin
        check("w1_latency", c - last_acc, 2);
        if (qa.size() == 0) begin
          check("w1_unexpected_result", 1, 0);
        end else begin
          ea = qa.pop_front(); eb = qb.pop_front();
          check("w1_diff", bus1.diff, ref_diff(1, ea, eb));
          check("w1_borrow", bus1.borrow, ref_borrow(ea, eb));
`ifdef SERIAL_SUB_OVF_EN
          check("w1_ovf", bus1.ovf, ref_ovf(1, ea, eb));
`endif
          nres++;
        end
      end
      if (bus1.in_ready === 1'b1) begin
        if (last_acc >= 0) check("w1_period", c - last_acc, 3);
        qa.push_back(longint'(bus1.a));
        qb.push_back(longint'(bus1.b));
        last_acc = c;
      end
      @(negedge clk);
    end
    bus1.in_valid  = 1'b0;
    check("w1_result_count", (nres >= 4) ? 1 : 0, 1);

    // Drain the W=1 instance to be sure a lone op still finishes in two cycles.
    lat = 0;
    while (bus1.in_ready !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("w1_idle", bus1.in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
